// File: rtl/seq_fifo_pkg.sv
// Shared defaults and width helpers for the sequential-memory FIFO.
package seq_fifo_pkg;

  localparam int SEQ_FIFO_WIDTH_DEF = 8;
  localparam int SEQ_FIFO_DEPTH_DEF = 16;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seq_fifo_mem.sv
// Storage array with one enabled write port and one enabled synchronous read
// port; the registered read data doubles as the FIFO output register.
module seq_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [WIDTH-1:0]           rdata
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [WIDTH-1:0] r_rdata;

  // Array has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/seq_mem_fifo.sv
// Valid/ready FIFO over seq_fifo_mem with a registered head stage.
// Optional checks: define SEQ_MEM_FIFO_CHECK_EN.
module seq_mem_fifo
  import seq_fifo_pkg::*;
#(
  parameter int WIDTH = SEQ_FIFO_WIDTH_DEF,
  parameter int DEPTH = SEQ_FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      push_valid,
  output logic                      push_ready,
  input  logic [WIDTH-1:0]          push_data,
  output logic                      pop_valid,
  input  logic                      pop_ready,
  output logic [WIDTH-1:0]          pop_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_mem_cnt;
  logic          r_out_valid;

  logic          w_push_fire, w_pop_fire, w_load, w_re;
  logic [CW-1:0] w_count;

  assign w_count     = r_mem_cnt + CW'(r_out_valid);
  // Ready never looks at pop_ready, so a full FIFO stalls for one cycle on pop.
  assign push_ready  = rst_n & (w_count < DEPTH_C) & ~clr;
  assign pop_valid   = r_out_valid;
  assign w_push_fire = push_valid & push_ready;
  assign w_pop_fire  = r_out_valid & pop_ready;
  assign w_load      = (r_mem_cnt != '0) & (~r_out_valid | w_pop_fire);
  assign w_re        = w_load & ~clr;
  assign count       = w_count;

  seq_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (w_push_fire),
    .waddr (r_wr_ptr),
    .wdata (push_data),
    .re    (w_re),
    .raddr (r_rd_ptr),
    .rdata (pop_data)
  );

`ifdef SEQ_MEM_FIFO_CHECK_EN
  logic [PW-1:0] w_diff;
  logic [CW-1:0] w_exp_cnt;
  assign w_diff    = r_wr_ptr - r_rd_ptr;
  assign w_exp_cnt = (w_diff == '0 && r_mem_cnt != '0) ? DEPTH_C : CW'(w_diff);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mem_cnt   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push_fire) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_load)      r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push_fire, w_load})
        2'b10:   r_mem_cnt <= r_mem_cnt + CW'(1);
        2'b01:   r_mem_cnt <= r_mem_cnt - CW'(1);
        default: r_mem_cnt <= r_mem_cnt;
      endcase
      if (w_load)          r_out_valid <= 1'b1;
      else if (w_pop_fire) r_out_valid <= 1'b0;
    end
`ifdef SEQ_MEM_FIFO_CHECK_EN
    if (rst_n) begin
      assert (w_count <= DEPTH_C);
      assert (r_mem_cnt == w_exp_cnt);
      if (push_valid && !push_ready) $display("push stall count=%0d", w_count);
    end
`endif
  end

endmodule
